// File: rtl/elevator_pkg.sv
// Shared elevator types and request helpers used by the dispatcher slice.
// Pure combinational helpers; no state and no flow control.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] fmask_t;

    typedef struct packed {
        logic   valid;
        floor_t floor;
    } req_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARRIVE = 3'd1,
        DOOR   = 3'd2,
        OFFER  = 3'd3,
        WAKE   = 3'd4
    } disp_state_t;

    function automatic req_t encode_req(input floor_t f);
        req_t r;
        r.valid = 1'b1;
        r.floor = f;
        return r;
    endfunction

    function automatic fmask_t floor_bit(input floor_t f);
        return fmask_t'(1) << f;
    endfunction

    // Floors strictly beyond cur in direction dir (1 = up).
    function automatic fmask_t ahead_mask(input floor_t cur, input logic dir);
        fmask_t m;
        m = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            m[f] = dir ? (f > int'(cur)) : (f < int'(cur));
        end
        return m;
    endfunction

    // Closest pending floor beyond cur: lowest one going up, highest one going down.
    function automatic floor_t nearest_ahead(input fmask_t pend, input floor_t cur, input logic dir);
        fmask_t a;
        floor_t r;
        a = pend & ahead_mask(cur, dir);
        r = cur;
        if (dir) begin
            for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
                if (a[f]) r = floor_t'(f);
            end
        end else begin
            for (int f = 0; f < NUM_FLOORS; f++) begin
                if (a[f]) r = floor_t'(f);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/door_timer.sv
// Door hold timer: load/reload to CYCLES-1, counts down while enabled, done when it reaches zero.
// Done is combinational from the count; a load in the same cycle suppresses done.
module door_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);
    localparam int W = $clog2(CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CYCLES - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = en & ~load & (cnt == '0);

endmodule

// File: rtl/request_dispatcher.sv
// Latches cabin/hall buttons and feeds requests/acks to the car FSM; buttons visible on pending one cycle later.
// FSM handshakes are edge-based (Delay, FR_Delay); macro DISPATCH_DOOR_REOPEN_EN lets current-floor presses extend the door.
module request_dispatcher
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 16,
    parameter int ACK_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cab_btn,
    input  logic [2:0] hall_up_btn,
    input  logic [2:0] hall_dn_btn,
    input  logic       Delay,
    input  logic [1:0] Actual_Stage,
    input  logic       UD_Answer,
    input  logic       FR_Delay,
    input  logic [2:0] Solicitud_stage,
    input  logic       STOP,
    output logic [2:0] next_stage,
    output logic       OC_Request,
    output logic       UD_Request,
    output logic       NO_STOP,
    output logic       DoneDelay,
    output logic [3:0] pending
);
    fmask_t      cab_q, up_q, dn_q, pend, cur_oh, hu4, hd4, clr_up, clr_dn;
    fmask_t      ahead, above, below, sup_cab, sup_up, sup_dn;
    logic        delay_q, fr_q, delay_rise, fr_rise, arrive_acc;
    logic        last_dir, dir_eff, ud_q, ud_calc, no_stop;
    logic        do_clear, svc_hit, local_only, reopen, timer_load, timer_done, in_door;
    logic [7:0]  ack_cnt;
    disp_state_t state, state_nxt;
    req_t        offer_q, offer_nxt;

    assign pend       = cab_q | up_q | dn_q;
    assign cur_oh     = floor_bit(Actual_Stage);
    assign hu4        = {1'b0, hall_up_btn};
    assign hd4        = {hall_dn_btn, 1'b0};
    assign delay_rise = Delay & ~delay_q;
    assign fr_rise    = FR_Delay & ~fr_q;
    assign arrive_acc = delay_rise & ((state == IDLE) | (state == OFFER));
    assign in_door    = (state == DOOR);

    // End floors only allow one way out, whatever direction was last recorded.
    assign dir_eff = (Actual_Stage == 2'd0) ? 1'b1 :
                     (Actual_Stage == 2'd3) ? 1'b0 : last_dir;

    assign clr_up     = dir_eff ? cur_oh : '0;
    assign clr_dn     = dir_eff ? '0 : cur_oh;
    assign svc_hit    = |((cab_q & cur_oh) | (up_q & clr_up) | (dn_q & clr_dn));
    assign ahead      = pend & ahead_mask(Actual_Stage, dir_eff);
    assign above      = pend & ahead_mask(Actual_Stage, 1'b1);
    assign below      = pend & ahead_mask(Actual_Stage, 1'b0);
    assign local_only = (pend == cur_oh);
    assign ud_calc    = (|above) ? 1'b1 : (|below) ? 1'b0 : dir_eff;

`ifdef DISPATCH_DOOR_REOPEN_EN
    // A press for the floor we are standing at just restarts the door hold.
    assign sup_cab = in_door ? (cab_btn & cur_oh) : '0;
    assign sup_up  = in_door ? (hu4 & clr_up) : '0;
    assign sup_dn  = in_door ? (hd4 & clr_dn) : '0;
`else
    assign sup_cab = '0;
    assign sup_up  = '0;
    assign sup_dn  = '0;
`endif
    assign reopen = |(sup_cab | sup_up | sup_dn);

    door_timer #(.CYCLES(DOOR_CYCLES)) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .en    (in_door),
        .done  (timer_done)
    );

    always_comb begin
        state_nxt  = state;
        offer_nxt  = offer_q;
        do_clear   = 1'b0;
        timer_load = 1'b0;
        no_stop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (delay_rise) begin
                    state_nxt = ARRIVE;
                end else if (STOP && (|pend)) begin
                    state_nxt = WAKE;
                end else if (!STOP && (|ahead)) begin
                    state_nxt = OFFER;
                    offer_nxt = encode_req(nearest_ahead(pend, Actual_Stage, dir_eff));
                end
            end
            ARRIVE: begin
                do_clear = 1'b1;
                if (svc_hit) begin
                    state_nxt  = DOOR;
                    timer_load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOOR: begin
                if (reopen) begin
                    timer_load = 1'b1;
                end else if (timer_done) begin
                    state_nxt = IDLE;
                end
            end
            OFFER: begin
                if (delay_rise) begin
                    offer_nxt = '0;
                    state_nxt = ARRIVE;
                end else if (fr_rise && (req_t'(Solicitud_stage) == offer_q)) begin
                    offer_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            WAKE: begin
                if (local_only) begin
                    do_clear = 1'b1;
                    if (svc_hit) begin
                        state_nxt  = DOOR;
                        timer_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    no_stop   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Clear is applied after set so a same-cycle press of a serviced bit is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            offer_q  <= '0;
            cab_q    <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            delay_q  <= 1'b0;
            fr_q     <= 1'b0;
            last_dir <= 1'b1;
            ud_q     <= 1'b1;
            ack_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            offer_q <= offer_nxt;
            delay_q <= Delay;
            fr_q    <= FR_Delay;
            cab_q   <= (cab_q | (cab_btn & ~sup_cab)) & ~(do_clear ? cur_oh : '0);
            up_q    <= (up_q | (hu4 & ~sup_up)) & ~(do_clear ? clr_up : '0);
            dn_q    <= (dn_q | (hd4 & ~sup_dn)) & ~(do_clear ? clr_dn : '0);
            if (arrive_acc) begin
                last_dir <= (Actual_Stage == 2'd0) ? 1'b1 :
                            (Actual_Stage == 2'd3) ? 1'b0 : UD_Answer;
            end
            if (state == WAKE) begin
                ud_q <= ud_calc;
            end
            if (state == ARRIVE) begin
                ack_cnt <= 8'(ACK_CYCLES - 1);
            end else if (ack_cnt != '0) begin
                ack_cnt <= ack_cnt - 1'b1;
            end
        end
    end

    assign next_stage = offer_q;
    assign OC_Request = in_door;
    assign UD_Request = (state == WAKE) ? ud_calc : ud_q;
    assign NO_STOP    = no_stop;
    assign DoneDelay  = (state == ARRIVE) | (ack_cnt != '0);
    assign pending    = pend;

endmodule

// File: tb/tb_request_dispatcher.sv
// Bench for request_dispatcher: arrival vector table with a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_request_dispatcher;
    localparam int DC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cab_btn;
    logic [2:0] hall_up_btn, hall_dn_btn;
    logic       Delay;
    logic [1:0] Actual_Stage;
    logic       UD_Answer, FR_Delay, STOP;
    logic [2:0] Solicitud_stage;
    logic [2:0] next_stage;
    logic       OC_Request, UD_Request, NO_STOP, DoneDelay;
    logic [3:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0] stage;
        logic       ud;
        logic [3:0] cab;
        logic [2:0] hup;
        logic [2:0] hdn;
        logic [3:0] epend;
        logic       edoor;
    } vec_t;

    typedef struct {
        logic [3:0] pend;
        logic       door;
    } exp_t;

    vec_t vt[9];
    exp_t sb[$];

    always #5 clk = ~clk;

    request_dispatcher #(.DOOR_CYCLES(DC), .ACK_CYCLES(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .cab_btn         (cab_btn),
        .hall_up_btn     (hall_up_btn),
        .hall_dn_btn     (hall_dn_btn),
        .Delay           (Delay),
        .Actual_Stage    (Actual_Stage),
        .UD_Answer       (UD_Answer),
        .FR_Delay        (FR_Delay),
        .Solicitud_stage (Solicitud_stage),
        .STOP            (STOP),
        .next_stage      (next_stage),
        .OC_Request      (OC_Request),
        .UD_Request      (UD_Request),
        .NO_STOP         (NO_STOP),
        .DoneDelay       (DoneDelay),
        .pending         (pending)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cab_btn = '0; hall_up_btn = '0; hall_dn_btn = '0;
        Delay = 1'b0; Actual_Stage = '0; UD_Answer = 1'b0;
        FR_Delay = 1'b0; Solicitud_stage = '0; STOP = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press(input logic [3:0] c, input logic [2:0] u, input logic [2:0] d);
        cab_btn = c; hall_up_btn = u; hall_dn_btn = d;
        @(negedge clk);
        cab_btn = '0; hall_up_btn = '0; hall_dn_btn = '0;
    endtask

    task automatic wait_offer();
        int w;
        w = 0;
        while (next_stage == 3'b000 && w < 8) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Arrival: expectation queued at the Delay edge, popped once DoneDelay is seen.
    task automatic arrive(input logic [1:0] st, input logic ud, input logic [3:0] epend, input logic edoor,
                          input logic [3:0] pcab, input int pat, input int ew);
        exp_t e;
        int   w;
        int   cnt;
        sb.push_back('{pend: epend, door: edoor});
        Actual_Stage = st; UD_Answer = ud; Delay = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!DoneDelay && w < 8);
        check("done_delay", int'(DoneDelay), 1);
        Delay = 1'b0;
        @(negedge clk);
        check("done_width", int'(DoneDelay), 0);
        e = sb.pop_front();
        check("arr_pending", int'(pending), int'(e.pend));
        check("arr_door", int'(OC_Request), int'(e.door));
        if (e.door) begin
            cnt = 0;
            while (OC_Request && cnt < 200) begin
                cnt++;
                cab_btn = (cnt == pat) ? pcab : 4'b0000;
                @(negedge clk);
            end
            cab_btn = '0;
            check("door_width", cnt, ew);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        vt[0] = '{2'd2, 1'b1, 4'b0100, 3'b000, 3'b000, 4'b0000, 1'b1};
        vt[1] = '{2'd2, 1'b1, 4'b0000, 3'b000, 3'b010, 4'b0100, 1'b0};
        vt[2] = '{2'd2, 1'b1, 4'b0000, 3'b100, 3'b010, 4'b0100, 1'b1};
        vt[3] = '{2'd1, 1'b0, 4'b0000, 3'b010, 3'b001, 4'b0010, 1'b1};
        vt[4] = '{2'd3, 1'b1, 4'b0001, 3'b000, 3'b100, 4'b0001, 1'b1};
        vt[5] = '{2'd0, 1'b0, 4'b1000, 3'b001, 3'b000, 4'b1000, 1'b1};
        vt[6] = '{2'd1, 1'b1, 4'b0100, 3'b000, 3'b000, 4'b0100, 1'b0};
        vt[7] = '{2'd0, 1'b1, 4'b0001, 3'b010, 3'b000, 4'b0010, 1'b1};
        vt[8] = '{2'd3, 1'b1, 4'b1000, 3'b100, 3'b000, 4'b0100, 1'b1};

        // Reset values
        do_reset();
        check("rst_next_stage", int'(next_stage), 0);
        check("rst_oc", int'(OC_Request), 0);
        check("rst_ud", int'(UD_Request), 1);
        check("rst_nostop", int'(NO_STOP), 0);
        check("rst_done", int'(DoneDelay), 0);
        check("rst_pending", int'(pending), 0);

        // Parked car woken by a cabin call above
        STOP = 1'b1; Actual_Stage = 2'd0;
        press(4'b1000, 3'b000, 3'b000);
        check("wake_pending", int'(pending), 4'b1000);
        w = 0;
        while (!NO_STOP && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("wake_nostop", int'(NO_STOP), 1);
        check("wake_ud", int'(UD_Request), 1);
        STOP = 1'b0;
        @(negedge clk);
        check("wake_nostop_width", int'(NO_STOP), 0);
        @(negedge clk);
        check("wake_then_offer", int'(next_stage), 3'b111);

        // Arrival table
        foreach (vt[i]) begin
            do_reset();
            press(vt[i].cab, vt[i].hup, vt[i].hdn);
            check("load_pending", int'(pending), int'(vt[i].cab | {1'b0, vt[i].hup} | {vt[i].hdn, 1'b0}));
            arrive(vt[i].stage, vt[i].ud, vt[i].epend, vt[i].edoor, 4'b0000, 0, DC);
        end

        // Offer, wrong echo, accept, re-offer, withdraw on arrival
        do_reset();
        Actual_Stage = 2'd1;
        press(4'b1100, 3'b000, 3'b000);
        wait_offer();
        check("offer_up", int'(next_stage), 3'b110);
        Solicitud_stage = 3'b101; FR_Delay = 1'b1;
        @(negedge clk);
        FR_Delay = 1'b0;
        check("offer_bad_echo", int'(next_stage), 3'b110);
        @(negedge clk);
        check("offer_hold", int'(next_stage), 3'b110);
        Solicitud_stage = 3'b110; FR_Delay = 1'b1;
        @(negedge clk);
        check("offer_accept", int'(next_stage), 3'b000);
        FR_Delay = 1'b0; Solicitud_stage = '0;
        @(negedge clk);
        check("offer_again", int'(next_stage), 3'b110);
        Delay = 1'b1; UD_Answer = 1'b1;
        @(negedge clk);
        check("withdraw_stage", int'(next_stage), 3'b000);
        check("withdraw_done", int'(DoneDelay), 1);
        Delay = 1'b0;
        @(negedge clk);
        check("withdraw_pending", int'(pending), 4'b1100);
        check("withdraw_no_door", int'(OC_Request), 0);

        // Downward offer after an arrival heading down
        do_reset();
        arrive(2'd2, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, DC);
        press(4'b0011, 3'b000, 3'b000);
        wait_offer();
        check("offer_down", int'(next_stage), 3'b101);

        // Current-floor press while the doors are open
        do_reset();
        Actual_Stage = 2'd2;
        press(4'b0100, 3'b000, 3'b000);
`ifdef DISPATCH_DOOR_REOPEN_EN
        arrive(2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 3, DC + 3);
        check("door_press_pending", int'(pending), 4'b0000);
`else
        arrive(2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 3, DC);
        check("door_press_pending", int'(pending), 4'b0100);
`endif

        // Reset in the middle of a door hold
        do_reset();
        Actual_Stage = 2'd2;
        press(4'b0101, 3'b000, 3'b000);
        Delay = 1'b1; UD_Answer = 1'b1;
        @(negedge clk);
        Delay = 1'b0;
        @(negedge clk);
        check("door_open", int'(OC_Request), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_door_rst_oc", int'(OC_Request), 0);
        check("mid_door_rst_pending", int'(pending), 0);
        check("mid_door_rst_ud", int'(UD_Request), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
